// File: rtl/prbs9_checker.sv
// Receive-side PRBS9 (x^9 + x^5 + 1) checker: self-synchronises to the serial stream,
// then flags and counts bit errors and drops lock when one window holds too many errors.
module prbs9_checker #(
  parameter int LOCK_CNT = 16,
  parameter int WINDOW   = 64,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic             i_data,
  input  logic             i_clr,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_THR + 1);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [8:0]         hist_q,    hist_d;
  logic [3:0]         fill_q,    fill_d;
  logic [MATCH_W-1:0] match_q,   match_d;
  logic [WIN_W-1:0]   win_q,     win_d;
  logic [WERR_W-1:0]  werr_q,    werr_d;
  logic               err_q,     err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic              qual;
  logic              pred;
  logic              mism;
  logic [WERR_W-1:0] werr_next;

  assign qual      = i_en && i_valid;
  assign pred      = hist_q[8] ^ hist_q[4];
  assign mism      = i_data ^ pred;
  // Window error count is always below LOSS_THR while locked, so this cannot overflow.
  assign werr_next = werr_q + WERR_W'(mism);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_d     = win_q;
    werr_d    = werr_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;

    if (qual) begin
      case (state_q)
        ST_FILL: begin
          hist_d = {hist_q[7:0], i_data};
          if (fill_q == 4'd8) begin
            fill_d  = '0;
            state_d = ST_SEARCH;
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
        ST_SEARCH: begin
          hist_d = {hist_q[7:0], i_data};
          // An all-zero history predicts zeros forever; never count that as sync.
          if (!mism && hist_q != '0) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d = ST_LOCKED;
              match_d = '0;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Feeding back the prediction keeps one flipped bit from corrupting later predictions.
          hist_d = {hist_q[7:0], pred};
          err_d  = mism;
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (mism && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (win_q == WIN_W'(WINDOW - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WIN_W'(1);
            werr_d = werr_next;
          end
          if (werr_next == WERR_W'(LOSS_THR)) begin
            state_d = ST_FILL;
            match_d = '0;
            fill_d  = '0;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end

    if (i_clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= ST_FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_q     <= '0;
      werr_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_q     <= win_d;
      werr_q    <= werr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign o_lock    = (state_q == ST_LOCKED);
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
  assign o_bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: a default-width instance and a CNT_W=4 instance
// share the same stimulus; a reference PRBS9 generator produces the expected stream.
module tb_prbs9_checker;

  logic        clk;
  logic        rst;
  logic        en;
  logic        valid;
  logic        data;
  logic        clr;
  logic        lock;
  logic        err;
  logic [31:0] err_cnt;
  logic [31:0] bit_cnt;
  logic        lock4;
  logic        err4;
  logic [3:0]  err_cnt4;
  logic [3:0]  bit_cnt4;

  logic [8:0]  g;
  int          errors;
  int          checks;

  prbs9_checker dut (
    .clk       (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_valid   (valid),
    .i_data    (data),
    .i_clr     (clr),
    .o_lock    (lock),
    .o_err     (err),
    .o_err_cnt (err_cnt),
    .o_bit_cnt (bit_cnt)
  );

  prbs9_checker #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_valid   (valid),
    .i_data    (data),
    .i_clr     (clr),
    .o_lock    (lock4),
    .o_err     (err4),
    .o_err_cnt (err_cnt4),
    .o_bit_cnt (bit_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en_v, input logic val_v, input logic dat_v, input logic clr_v);
    en    = en_v;
    valid = val_v;
    data  = dat_v;
    clr   = clr_v;
    @(posedge clk);
    #1;
  endtask

  // One qualified sample of the reference stream b[n] = b[n-9] ^ b[n-5], optionally inverted.
  task automatic prbs_sample(input logic flip, input logic clr_v);
    logic b;
    b = g[8] ^ g[4];
    g = {g[7:0], b};
    drive(1'b1, 1'b1, b ^ flip, clr_v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    g   = 9'h1AA;
  endtask

  // Feed 25 clean samples: lock must stay low through 24 and rise right after the 25th.
  task automatic lock_up(input string tag);
    int early;
    early = 0;
    for (int i = 1; i <= 25; i++) begin
      prbs_sample(1'b0, 1'b0);
      if (i < 25 && lock !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL %s_early_lock: lock high on %0d samples, expected 0", tag, early);
    end
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL %s_lock_25: lock=%b expected 1", tag, lock);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (lock !== 1'b0 || err !== 1'b0 || err_cnt !== 32'd0 || bit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: lock=%b err=%b err_cnt=%0d bit_cnt=%0d expected 0/0/0/0",
               lock, err, err_cnt, bit_cnt);
    end
  endtask

  task automatic test_lock();
    int err_seen;
    do_reset();
    lock_up("acquire");
    err_seen = 0;
    for (int i = 0; i < 9975; i++) begin
      prbs_sample(1'b0, 1'b0);
      if (err !== 1'b0 || lock !== 1'b1) err_seen++;
    end
    checks++;
    if (err_seen != 0) begin
      errors++;
      $display("FAIL clean_stream: %0d cycles with err or lost lock, expected 0", err_seen);
    end
    checks++;
    if (bit_cnt !== 32'd9975) begin
      errors++;
      $display("FAIL bit_cnt_clean: got %0d expected 9975", bit_cnt);
    end
  endtask

  task automatic test_single_err();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_cnt !== 32'd0 || bit_cnt !== 32'd0 || lock !== 1'b1) begin
      errors++;
      $display("FAIL clr_idle: err_cnt=%0d bit_cnt=%0d lock=%b expected 0/0/1", err_cnt, bit_cnt, lock);
    end
    for (int i = 0; i < 5; i++) prbs_sample(1'b0, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL single_pre: err=%b expected 0", err);
    end
    prbs_sample(1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || err_cnt !== 32'd1) begin
      errors++;
      $display("FAIL single_pulse: err=%b err_cnt=%0d expected 1/1", err, err_cnt);
    end
    prbs_sample(1'b0, 1'b0);
    checks++;
    if (err !== 1'b0 || err_cnt !== 32'd1 || lock !== 1'b1 || bit_cnt !== 32'd7) begin
      errors++;
      $display("FAIL single_after: err=%b err_cnt=%0d lock=%b bit_cnt=%0d expected 0/1/1/7",
               err, err_cnt, lock, bit_cnt);
    end
  endtask

  task automatic test_loss();
    do_reset();
    lock_up("loss_pre");
    for (int k = 0; k <= 30; k++) begin
      prbs_sample((k % 4) == 2, 1'b0);
      if (k == 26) begin
        checks++;
        if (lock !== 1'b1) begin
          errors++;
          $display("FAIL loss_seven: lock=%b expected 1 after 7 errors", lock);
        end
      end
    end
    checks++;
    if (lock !== 1'b0 || err !== 1'b1 || err_cnt !== 32'd8) begin
      errors++;
      $display("FAIL loss_eight: lock=%b err=%b err_cnt=%0d expected 0/1/8", lock, err, err_cnt);
    end
    lock_up("relock");
    checks++;
    if (err_cnt !== 32'd8 || bit_cnt !== 32'd31) begin
      errors++;
      $display("FAIL relock_counts: err_cnt=%0d bit_cnt=%0d expected 8/31", err_cnt, bit_cnt);
    end
  endtask

  // 7 errors at the end of the first window plus 1 at the start of the next must not drop lock.
  task automatic test_window_wrap();
    do_reset();
    lock_up("wrap_pre");
    for (int k = 0; k <= 64; k++) prbs_sample(k >= 57, 1'b0);
    checks++;
    if (lock !== 1'b1 || err_cnt !== 32'd8) begin
      errors++;
      $display("FAIL window_wrap: lock=%b err_cnt=%0d expected 1/8", lock, err_cnt);
    end
  endtask

  task automatic test_zero_ones();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b1, i >= 500, 1'b0);
      if (lock !== 1'b0 || err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL const_stream_lock: %0d cycles locked or err, expected 0", bad);
    end
    checks++;
    if (err_cnt !== 32'd0 || bit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL const_stream_cnt: err_cnt=%0d bit_cnt=%0d expected 0/0", err_cnt, bit_cnt);
    end
  endtask

  task automatic test_valid_gaps();
    int          q;
    int          cyc;
    int          bad;
    logic [31:0] prev_bc;
    logic        e_v;
    logic        v_v;
    do_reset();
    q   = 0;
    cyc = 0;
    bad = 0;
    while (q < 225 && cyc < 4000) begin
      e_v     = ($urandom_range(0, 7) != 0);
      v_v     = $urandom_range(0, 1) != 0;
      prev_bc = bit_cnt;
      if (e_v && v_v) begin
        prbs_sample(1'b0, 1'b0);
        q++;
      end else begin
        drive(e_v, v_v, $urandom_range(0, 1) != 0, 1'b0);
        if (bit_cnt !== prev_bc) bad++;
      end
      cyc++;
      checks++;
      if (lock !== (q >= 25) || err !== 1'b0) begin
        errors++;
        $display("FAIL gaps_cycle%0d: lock=%b err=%b expected %b/0 after %0d samples",
                 cyc, lock, err, q >= 25, q);
      end
    end
    checks++;
    if (q != 225) begin
      errors++;
      $display("FAIL gaps_budget: %0d qualified samples, expected 225", q);
    end
    checks++;
    if (bad != 0 || bit_cnt !== 32'd200) begin
      errors++;
      $display("FAIL gaps_bit_cnt: idle_changes=%0d bit_cnt=%0d expected 0/200", bad, bit_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    lock_up("sat_pre");
    for (int n = 1; n <= 20; n++) begin
      for (int i = 0; i < 15; i++) prbs_sample(1'b0, 1'b0);
      prbs_sample(1'b1, 1'b0);
      checks++;
      if (err_cnt4 !== 4'((n > 15) ? 15 : n) || err_cnt !== 32'(n) || err4 !== 1'b1) begin
        errors++;
        $display("FAIL sat_err%0d: err_cnt4=%0d err_cnt=%0d err4=%b expected %0d/%0d/1",
                 n, err_cnt4, err_cnt, err4, (n > 15) ? 15 : n, n);
      end
    end
    checks++;
    if (bit_cnt4 !== 4'd15 || bit_cnt !== 32'd320 || lock4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_bits: bit_cnt4=%0d bit_cnt=%0d lock4=%b expected 15/320/1", bit_cnt4, bit_cnt, lock4);
    end
    prbs_sample(1'b1, 1'b1);
    checks++;
    if (err_cnt4 !== 4'd0 || bit_cnt4 !== 4'd0 || err_cnt !== 32'd0 || bit_cnt !== 32'd0
        || err4 !== 1'b1 || lock4 !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_err: err_cnt4=%0d bit_cnt4=%0d err_cnt=%0d bit_cnt=%0d err4=%b lock4=%b expected 0/0/0/0/1/1",
               err_cnt4, bit_cnt4, err_cnt, bit_cnt, err4, lock4);
    end
    for (int i = 0; i < 3; i++) prbs_sample(1'b0, 1'b0);
    rst = 1'b1;
    prbs_sample(1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if (lock !== 1'b0 || err !== 1'b0 || err_cnt !== 32'd0 || bit_cnt !== 32'd0
        || lock4 !== 1'b0 || err4 !== 1'b0 || err_cnt4 !== 4'd0 || bit_cnt4 !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset: lock=%b err=%b err_cnt=%0d bit_cnt=%0d lock4=%b err4=%b err_cnt4=%0d bit_cnt4=%0d expected all 0",
               lock, err, err_cnt, bit_cnt, lock4, err4, err_cnt4, bit_cnt4);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    en     = 1'b0;
    valid  = 1'b0;
    data   = 1'b0;
    clr    = 1'b0;
    g      = 9'h1AA;
    test_reset();
    test_lock();
    test_single_err();
    test_loss();
    test_window_wrap();
    test_zero_ones();
    test_valid_gaps();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
